// File: rtl/mpc_mult_arbiter_if.sv
// Request/result bundle between the MPC datapath stages and the shared multiplier.
// The requester side uses the master modport; the arbiter uses the slave modport.
interface mpc_mult_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    i_req;
   logic [32*N_REQ-1:0] i_a;
   logic [32*N_REQ-1:0] i_b;
   logic                i_hold;
   logic [N_REQ-1:0]    o_gnt;
   logic [31:0]         o_result;
   logic [N_REQ-1:0]    o_valid;
   logic                o_busy;
   logic                o_sat;

   modport master (
      output i_req, i_a, i_b, i_hold,
      input  o_gnt, o_result, o_valid, o_busy, o_sat
   );

   modport slave (
      input  i_req, i_a, i_b, i_hold,
      output o_gnt, o_result, o_valid, o_busy, o_sat
   );
endinterface

// File: rtl/mpc_mult_arbiter.sv
// Round-robin shared signed Q16.16 multiplier with fixed-latency, one-hot tagged results.
// Define MPC_MULT_SAT_EN to clamp out-of-range products and raise the sticky o_sat flag.
module mpc_mult_arbiter #(
   parameter int N_REQ = 4,
   parameter int LAT   = 3,
   parameter int FRAC  = 16
) (
   input logic              i_clk,
   input logic              i_rst,
   mpc_mult_arbiter_if.slave bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int ND = (LAT > 1) ? LAT - 1 : 1;

   logic [PW-1:0]       ptr_q, ptr_d;
   logic [N_REQ-1:0]    vld_q [LAT];
   logic [N_REQ-1:0]    vld_d [LAT];
   logic [63:0]         pipe_q [ND];
   logic [63:0]         pipe_d [ND];
   logic [31:0]         res_q, res_d;

   logic [N_REQ-1:0]    gnt;
   logic [PW-1:0]       sel;
   logic                found;
   logic [63:0]         ops_sel;
   logic signed [63:0]  fin_p;
   logic signed [63:0]  r;
   logic                busy;

   function automatic logic signed [63:0] mul64(input logic [63:0] ab);
      logic signed [63:0] x;
      logic signed [63:0] y;
      x = {{32{ab[63]}}, ab[63:32]};
      y = {{32{ab[31]}}, ab[31:0]};
      return x * y;
   endfunction

   // Search starts at ptr and wraps; reset and hold both suppress the grant.
   always_comb begin
      gnt   = '0;
      sel   = '0;
      found = 1'b0;
      if (!i_rst && !bus.i_hold) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.i_req[(int'(ptr_q) + i) % N_REQ]) begin
               found = 1'b1;
               sel   = PW'((int'(ptr_q) + i) % N_REQ);
            end
         end
      end
      if (found) gnt[sel] = 1'b1;
   end

   // Only the granted lane is muxed in, so junk on idle lanes never reaches the pipe.
   assign ops_sel = {bus.i_a[32*int'(sel) +: 32], bus.i_b[32*int'(sel) +: 32]};

   always_comb begin
      ptr_d = ptr_q;
      if (found) ptr_d = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;
   end

   always_comb begin
      vld_d[0] = gnt;
      for (int s = 1; s < LAT; s++) vld_d[s] = vld_q[s-1];
      pipe_d = pipe_q;
      if (found) pipe_d[0] = ops_sel;
      for (int s = 1; s < ND; s++) pipe_d[s] = (s == 1) ? mul64(pipe_q[0]) : pipe_q[s-1];
      fin_p = (LAT == 1) ? mul64(ops_sel) :
              (LAT == 2) ? mul64(pipe_q[0]) : pipe_q[ND-1];
      r = fin_p >>> FRAC;
   end

`ifdef MPC_MULT_SAT_EN
   localparam logic signed [63:0] R_MAX = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] R_MIN = -64'sh0000_0000_8000_0000;
   logic sat_q, sat_d;

   always_comb begin
      res_d = res_q;
      sat_d = sat_q;
      if (|vld_d[LAT-1]) begin
         if (r > R_MAX) begin
            res_d = 32'h7FFF_FFFF;
            sat_d = 1'b1;
         end else if (r < R_MIN) begin
            res_d = 32'h8000_0000;
            sat_d = 1'b1;
         end else begin
            res_d = r[31:0];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end

   assign bus.o_sat = sat_q;
`else
   logic unused_r_hi;

   always_comb begin
      res_d = res_q;
      if (|vld_d[LAT-1]) res_d = r[31:0];
   end

   // Wrapped result keeps only the low word of the shifted product.
   assign unused_r_hi = ^r[63:32];
   assign bus.o_sat   = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q <= '0;
         res_q <= '0;
         for (int s = 0; s < LAT; s++) vld_q[s] <= '0;
         for (int s = 0; s < ND; s++)  pipe_q[s] <= '0;
      end else begin
         ptr_q <= ptr_d;
         res_q <= res_d;
         for (int s = 0; s < LAT; s++) vld_q[s] <= vld_d[s];
         for (int s = 0; s < ND; s++)  pipe_q[s] <= pipe_d[s];
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < LAT; s++) busy = busy | (|vld_q[s]);
   end

   assign bus.o_gnt    = gnt;
   assign bus.o_valid  = vld_q[LAT-1];
   assign bus.o_result = res_q;
   assign bus.o_busy   = busy;
endmodule

// File: tb/tb_mpc_mult_arbiter.sv
// Scoreboard bench for mpc_mult_arbiter: per-requester op queues drive requests,
// a round-robin model predicts grants, and a monitor checks tagged results.
module tb_mpc_mult_arbiter;
   localparam int N   = 4;
   localparam int LAT = 3;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        clamp;
   } op_t;

   typedef struct {
      int          due;
      logic [N-1:0] tag;
      logic [31:0] res;
      logic        clamp;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mpc_mult_arbiter_if #(.N_REQ(N)) bus();

   mpc_mult_arbiter #(.N_REQ(N), .LAT(LAT), .FRAC(16)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   op_t  lane_q [N][$];
   sb_t  sb [$];
   int   grant_log [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   ptr_m = 0;
   logic hold_m = 1'b0;
   logic sat_m  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact 64-bit product, floor shift by 16, then clamp or wrap.
   function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b);
      op_t    o;
      longint p;
      longint r;
      p = longint'($signed(a)) * longint'($signed(b));
      r = p >>> 16;
      o.a = a;
      o.b = b;
      o.exp = r[31:0];
      o.clamp = 1'b0;
`ifdef MPC_MULT_SAT_EN
      if (r > 64'sh7FFFFFFF) begin
         o.exp = 32'h7FFFFFFF;
         o.clamp = 1'b1;
      end else if (r < -64'sh80000000) begin
         o.exp = 32'h80000000;
         o.clamp = 1'b1;
      end
`endif
      return o;
   endfunction

   function automatic op_t fixed_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] exp, input logic clamp);
      op_t o;
      o.a = a;
      o.b = b;
      o.exp = exp;
      o.clamp = clamp;
      return o;
   endfunction

   function automatic logic [31:0] rnd_operand();
      logic [31:0] r;
      logic [31:0] corners [5];
      corners = '{32'h0, 32'h00010000, 32'hFFFF0000, 32'h7FFFFFFF, 32'h80000000};
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return r;
         1: return {{12{r[19]}}, r[19:0]};
         2: return {{8{r[23]}}, r[23:0]};
         default: return corners[$urandom_range(0, 4)];
      endcase
   endfunction

   function automatic int log_at(input int i);
      return (i < grant_log.size()) ? grant_log[i] : -1;
   endfunction

   function automatic bit all_idle();
      for (int k = 0; k < N; k++) if (lane_q[k].size() != 0) return 1'b0;
      return sb.size() == 0;
   endfunction

   task automatic drive_inputs();
      logic [N-1:0]    req;
      logic [32*N-1:0] av;
      logic [32*N-1:0] bv;
      for (int k = 0; k < N; k++) begin
         if (lane_q[k].size() != 0) begin
            req[k] = 1'b1;
            av[32*k +: 32] = lane_q[k][0].a;
            bv[32*k +: 32] = lane_q[k][0].b;
         end else begin
            req[k] = 1'b0;
            av[32*k +: 32] = $urandom;
            bv[32*k +: 32] = $urandom;
         end
      end
      bus.i_req  = req;
      bus.i_a    = av;
      bus.i_b    = bv;
      bus.i_hold = hold_m;
   endtask

   // Winner is the pending requester at the smallest forward distance from the pointer.
   task automatic check_grant();
      logic [N-1:0] exp_gnt;
      int  k;
      int  best;
      int  d;
      sb_t it;
      exp_gnt = '0;
      k = -1;
      best = N;
      if (!rst && !hold_m) begin
         for (int j = 0; j < N; j++) begin
            d = (j - ptr_m + N) % N;
            if (lane_q[j].size() != 0 && d < best) begin
               best = d;
               k = j;
            end
         end
      end
      if (k >= 0) exp_gnt[k] = 1'b1;
      chk("gnt", 32'(bus.o_gnt), 32'(exp_gnt));
      if (k >= 0) begin
         it.due   = cyc + LAT;
         it.tag   = exp_gnt;
         it.res   = lane_q[k][0].exp;
         it.clamp = lane_q[k][0].clamp;
         sb.push_back(it);
         void'(lane_q[k].pop_front());
         ptr_m = (k + 1) % N;
         grant_log.push_back(k);
      end
   endtask

   task automatic step();
      drive_inputs();
      @(negedge clk);
      check_grant();
      @(posedge clk);
      #1;
   endtask

   task automatic run_idle(input int bound);
      for (int n = 0; ; n++) begin
         if (all_idle()) break;
         if (n >= bound) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got pending=%0d expected pending=0", sb.size());
            for (int k = 0; k < N; k++) lane_q[k].delete();
            sb.delete();
            break;
         end
         step();
      end
   endtask

   always @(negedge clk) begin
      logic eb;
      sb_t  it;
      eb = 1'b0;
      foreach (sb[i]) if (sb[i].due >= cyc && sb[i].due < cyc + LAT) eb = 1'b1;
      chk("busy", 32'(bus.o_busy), 32'(eb));
      while (sb.size() != 0 && sb[0].due < cyc) begin
         chk("late_valid", 32'(bus.o_valid), 32'(sb[0].tag));
         void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].due == cyc) begin
         it = sb.pop_front();
         sat_m = sat_m | it.clamp;
         chk("valid_tag", 32'(bus.o_valid), 32'(it.tag));
         chk("result", bus.o_result, it.res);
         chk("sat", 32'(bus.o_sat), 32'(sat_m));
         $display("result tag=%b res=%h sat=%b", bus.o_valid, bus.o_result, bus.o_sat);
      end else begin
         chk("no_valid", 32'(bus.o_valid), 32'h0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_req  = '0;
      bus.i_a    = '0;
      bus.i_b    = '0;
      bus.i_hold = 1'b0;
      repeat (3) step();
      chk("rst_result", bus.o_result, 32'h0);
      chk("rst_sat",    32'(bus.o_sat), 32'h0);
      chk("rst_valid",  32'(bus.o_valid), 32'h0);
      chk("rst_busy",   32'(bus.o_busy), 32'h0);
      rst = 1'b0;

      // All four requesting from ptr=0: strict rotation.
      for (int k = 0; k < N; k++)
         repeat (2) lane_q[k].push_back(mk_op(rnd_operand(), rnd_operand()));
      grant_log.delete();
      run_idle(100);
      for (int i = 0; i < 8; i++) chk("rr_order", 32'(log_at(i)), 32'(i % N));

      lane_q[0].push_back(fixed_op(32'h00018000, 32'h00020000, 32'h00030000, 1'b0));
      run_idle(50);

      lane_q[0].push_back(fixed_op(32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0));
      lane_q[0].push_back(fixed_op(32'hFFFFFFFF, 32'h00008000, 32'hFFFFFFFF, 1'b0));
`ifdef MPC_MULT_SAT_EN
      lane_q[0].push_back(fixed_op(32'h7FFF0000, 32'h00020000, 32'h7FFFFFFF, 1'b1));
`else
      lane_q[0].push_back(fixed_op(32'h7FFF0000, 32'h00020000, 32'hFFFE0000, 1'b0));
`endif
      run_idle(50);

      // Hold with requests pending while an earlier op drains.
      lane_q[3].push_back(mk_op(rnd_operand(), rnd_operand()));
      step();
      grant_log.delete();
      hold_m = 1'b1;
      lane_q[1].push_back(mk_op(rnd_operand(), rnd_operand()));
      lane_q[2].push_back(mk_op(rnd_operand(), rnd_operand()));
      repeat (4) step();
      chk("hold_no_grant", 32'(grant_log.size()), 32'h0);
      chk("hold_drained", 32'(bus.o_busy), 32'h0);
      hold_m = 1'b0;
      run_idle(50);
      chk("hold_resume0", 32'(log_at(0)), 32'd1);
      chk("hold_resume1", 32'(log_at(1)), 32'd2);

      // Asynchronous reset with two ops in flight.
      lane_q[0].push_back(mk_op(rnd_operand(), rnd_operand()));
      lane_q[1].push_back(mk_op(rnd_operand(), rnd_operand()));
      lane_q[2].push_back(mk_op(rnd_operand(), rnd_operand()));
      step();
      step();
      #2;
      rst = 1'b1;
      sb.delete();
      ptr_m = 0;
      sat_m = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.o_valid), 32'h0);
      chk("arst_busy",  32'(bus.o_busy), 32'h0);
      chk("arst_gnt",   32'(bus.o_gnt), 32'h0);
      step();
      step();
      rst = 1'b0;
      lane_q[3].push_back(mk_op(rnd_operand(), rnd_operand()));
      grant_log.delete();
      run_idle(50);
      chk("post_rst_first", 32'(log_at(0)), 32'd2);

      // Random traffic with occasional hold.
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < N; k++)
            if (lane_q[k].size() == 0 && $urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 3)) lane_q[k].push_back(mk_op(rnd_operand(), rnd_operand()));
         hold_m = ($urandom_range(0, 9) == 0);
         step();
      end
      hold_m = 1'b0;
      run_idle(400);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
